// File: rtl/axis_pkt_accum_pkg.sv
// +--------------------------------------------------------------------------+
// | axis_pkt_accum_pkg                                                       |
// | Shared types and width helpers for the AXI-Stream packet accumulator.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package axis_pkt_accum_pkg;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      SEND  = 1'b1
   } accum_state_e;

   // The beat counter must hold MAX_BEATS+1 so that an overlength beat is visible.
   function automatic int beat_cnt_w(input int max_beats);
      return $clog2(max_beats + 2);
   endfunction

endpackage

`default_nettype wire

// File: rtl/axis_pkt_accum.sv
// +--------------------------------------------------------------------------+
// | axis_pkt_accum                                                           |
// | Sums each AXI-Stream packet and emits a single-beat result packet.       |
// | Optional statistics counters: define AXIS_PKT_ACCUM_STATS_EN.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module axis_pkt_accum
   import axis_pkt_accum_pkg::*;
#(
   parameter int TDATAW      = 32,
   parameter int TDESTW      = 4,
   parameter int RESULT_DEST = 0,
   parameter int MAX_BEATS   = 16
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              AXIS_S_TVALID,
   output logic              AXIS_S_TREADY,
   input  logic [TDATAW-1:0] AXIS_S_TDATA,
   input  logic              AXIS_S_TLAST,
   input  logic [TDESTW-1:0] AXIS_S_TDEST,
   output logic              AXIS_M_TVALID,
   input  logic              AXIS_M_TREADY,
   output logic [TDATAW-1:0] AXIS_M_TDATA,
   output logic              AXIS_M_TLAST,
   output logic [TDESTW-1:0] AXIS_M_TDEST,
`ifdef AXIS_PKT_ACCUM_STATS_EN
   output logic [31:0]       STAT_PKTS,
   output logic [31:0]       STAT_BEATS,
`endif
   output logic              ERR
);

   localparam int                BW          = beat_cnt_w(MAX_BEATS);
   localparam logic [BW-1:0]     c_BEATS_SAT = BW'(MAX_BEATS + 1);
   localparam logic [BW-1:0]     c_BEATS_MAX = BW'(MAX_BEATS);
   localparam logic [TDESTW-1:0] c_DEST      = TDESTW'(RESULT_DEST);

   accum_state_e      r_state;
   accum_state_e      w_state_nxt;
   logic              r_s_ready;
   logic [TDATAW-1:0] r_sum;
   logic [BW-1:0]     r_beats;
   logic [TDATAW-1:0] r_m_data;
   logic              r_m_valid;
   logic              r_m_last;
   logic              r_err;

   logic              w_s_hs;
   logic              w_m_hs;
   logic              w_last_hs;
   logic [BW-1:0]     w_beats_inc;
   logic [TDATAW-1:0] w_sum_nxt;
   logic              w_unused_tdest;

   assign w_s_hs         = AXIS_S_TVALID & r_s_ready;
   assign w_m_hs         = r_m_valid & AXIS_M_TREADY;
   assign w_last_hs      = w_s_hs & AXIS_S_TLAST;
   assign w_beats_inc    = (r_beats == c_BEATS_SAT) ? r_beats : r_beats + 1'b1;
   assign w_sum_nxt      = r_sum + AXIS_S_TDATA;
   assign w_unused_tdest = ^AXIS_S_TDEST;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ACCUM:   if (w_last_hs) w_state_nxt = SEND;
         SEND:    if (w_m_hs)    w_state_nxt = ACCUM;
         default: w_state_nxt = ACCUM;
      endcase
   end

   // Ready is registered so it stays low while reset is held.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state   <= ACCUM;
         r_s_ready <= 1'b0;
         r_m_valid <= 1'b0;
         r_m_last  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_s_ready <= (w_state_nxt == ACCUM);
         r_m_valid <= (w_state_nxt == SEND);
         r_m_last  <= (w_state_nxt == SEND);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_sum    <= '0;
         r_beats  <= '0;
         r_m_data <= '0;
         r_err    <= 1'b0;
      end else if (w_s_hs) begin
         if (w_beats_inc > c_BEATS_MAX) r_err <= 1'b1;
         if (AXIS_S_TLAST) begin
            r_m_data <= w_sum_nxt;
            r_sum    <= '0;
            r_beats  <= '0;
         end else begin
            r_sum    <= w_sum_nxt;
            r_beats  <= w_beats_inc;
         end
      end
   end

`ifdef AXIS_PKT_ACCUM_STATS_EN
   logic [31:0] r_stat_pkts;
   logic [31:0] r_stat_beats;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_stat_pkts  <= '0;
         r_stat_beats <= '0;
      end else begin
         if (w_m_hs) r_stat_pkts  <= r_stat_pkts + 32'd1;
         if (w_s_hs) r_stat_beats <= r_stat_beats + 32'd1;
      end
   end

   assign STAT_PKTS  = r_stat_pkts;
   assign STAT_BEATS = r_stat_beats;
`endif

   assign AXIS_S_TREADY = r_s_ready;
   assign AXIS_M_TVALID = r_m_valid;
   assign AXIS_M_TDATA  = r_m_data;
   assign AXIS_M_TLAST  = r_m_last;
   assign AXIS_M_TDEST  = c_DEST;
   assign ERR           = r_err;

endmodule

`default_nettype wire

// File: tb/tb_axis_pkt_accum.sv
// +--------------------------------------------------------------------------+
// | tb_axis_pkt_accum                                                        |
// | Directed self-checking bench for axis_pkt_accum.                         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_axis_pkt_accum;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        AXIS_S_TVALID = 1'b0;
   logic        AXIS_S_TREADY;
   logic [31:0] AXIS_S_TDATA = '0;
   logic        AXIS_S_TLAST = 1'b0;
   logic [3:0]  AXIS_S_TDEST = 4'h5;
   logic        AXIS_M_TVALID;
   logic        AXIS_M_TREADY = 1'b1;
   logic [31:0] AXIS_M_TDATA;
   logic        AXIS_M_TLAST;
   logic [3:0]  AXIS_M_TDEST;
   logic        ERR;
`ifdef AXIS_PKT_ACCUM_STATS_EN
   logic [31:0] STAT_PKTS;
   logic [31:0] STAT_BEATS;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   axis_pkt_accum #(
      .TDATAW      (32),
      .TDESTW      (4),
      .RESULT_DEST (0),
      .MAX_BEATS   (16)
   ) u_dut (
      .CLK           (CLK),
      .RST_N         (RST_N),
      .AXIS_S_TVALID (AXIS_S_TVALID),
      .AXIS_S_TREADY (AXIS_S_TREADY),
      .AXIS_S_TDATA  (AXIS_S_TDATA),
      .AXIS_S_TLAST  (AXIS_S_TLAST),
      .AXIS_S_TDEST  (AXIS_S_TDEST),
      .AXIS_M_TVALID (AXIS_M_TVALID),
      .AXIS_M_TREADY (AXIS_M_TREADY),
      .AXIS_M_TDATA  (AXIS_M_TDATA),
      .AXIS_M_TLAST  (AXIS_M_TLAST),
      .AXIS_M_TDEST  (AXIS_M_TDEST),
`ifdef AXIS_PKT_ACCUM_STATS_EN
      .STAT_PKTS     (STAT_PKTS),
      .STAT_BEATS    (STAT_BEATS),
`endif
      .ERR           (ERR)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Offers one beat, waiting a bounded time for ready; returns #1 after the accepting edge.
   task automatic send_beat(input logic [31:0] d, input logic l);
      int n = 0;
      AXIS_S_TVALID = 1'b1;
      AXIS_S_TDATA  = d;
      AXIS_S_TLAST  = l;
      while (!AXIS_S_TREADY && n < 50) begin
         tick();
         n++;
      end
      if (!AXIS_S_TREADY) check("s_ready_timeout", 32'd0, 32'd1);
      tick();
      AXIS_S_TVALID = 1'b0;
      AXIS_S_TLAST  = 1'b0;
   endtask

   // Called right after the TLAST beat edge with AXIS_M_TREADY=1.
   task automatic expect_result(input string tag, input logic [31:0] exp, input logic exp_err);
      check({tag, "_valid"}, {31'd0, AXIS_M_TVALID}, 32'd1);
      check({tag, "_data"},  AXIS_M_TDATA, exp);
      check({tag, "_err"},   {31'd0, ERR}, {31'd0, exp_err});
      tick();
      check({tag, "_done"},  {31'd0, AXIS_M_TVALID}, 32'd0);
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      #7;
      RST_N = 1'b1;
      tick();
   endtask

   initial begin
      // Reset values
      #2;
      check("rst_s_ready", {31'd0, AXIS_S_TREADY}, 32'd0);
      check("rst_m_valid", {31'd0, AXIS_M_TVALID}, 32'd0);
      check("rst_m_data",  AXIS_M_TDATA, 32'd0);
      check("rst_m_last",  {31'd0, AXIS_M_TLAST}, 32'd0);
      check("rst_m_dest",  {28'd0, AXIS_M_TDEST}, 32'd0);
      check("rst_err",     {31'd0, ERR}, 32'd0);
      #10;
      RST_N = 1'b1;
      tick();
      check("post_rst_s_ready", {31'd0, AXIS_S_TREADY}, 32'd1);

      // Basic sum
      send_beat(32'd1, 1'b0);
      send_beat(32'd2, 1'b0);
      send_beat(32'd3, 1'b0);
      send_beat(32'd4, 1'b1);
      check("basic_last",    {31'd0, AXIS_M_TLAST}, 32'd1);
      check("basic_dest",    {28'd0, AXIS_M_TDEST}, 32'd0);
      check("basic_s_ready", {31'd0, AXIS_S_TREADY}, 32'd0);
      expect_result("basic", 32'd10, 1'b0);
      check("basic_s_ready_back", {31'd0, AXIS_S_TREADY}, 32'd1);

      // Backpressure
      AXIS_M_TREADY = 1'b0;
      send_beat(32'h5, 1'b0);
      send_beat(32'h7, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid",   {31'd0, AXIS_M_TVALID}, 32'd1);
         check("bp_data",    AXIS_M_TDATA, 32'hC);
         check("bp_s_ready", {31'd0, AXIS_S_TREADY}, 32'd0);
         tick();
      end
      AXIS_M_TREADY = 1'b1;
      check("bp_hold_data", AXIS_M_TDATA, 32'hC);
      tick();
      check("bp_released_valid",   {31'd0, AXIS_M_TVALID}, 32'd0);
      check("bp_released_s_ready", {31'd0, AXIS_S_TREADY}, 32'd1);

      // Wrap-around and single-beat packet
      send_beat(32'hFFFF_FFFF, 1'b0);
      send_beat(32'h0000_0002, 1'b1);
      expect_result("wrap", 32'h0000_0001, 1'b0);
      send_beat(32'hAB, 1'b1);
      expect_result("single", 32'hAB, 1'b0);

      // Exactly MAX_BEATS is legal, one more sets ERR
      for (int i = 0; i < 16; i++) send_beat(32'd1, 1'b0);
      check("max_beats_no_err", {31'd0, ERR}, 32'd0);
      send_beat(32'd1, 1'b1);
      expect_result("overlen", 32'd17, 1'b1);
      send_beat(32'd1, 1'b0);
      send_beat(32'd2, 1'b0);
      send_beat(32'd3, 1'b1);
      expect_result("after_overlen", 32'd6, 1'b1);

      // Reset while a result is pending
      AXIS_M_TREADY = 1'b0;
      send_beat(32'h10, 1'b0);
      send_beat(32'h20, 1'b1);
      check("pend_data", AXIS_M_TDATA, 32'h30);
      RST_N = 1'b0;
      #1;
      check("midrst_valid", {31'd0, AXIS_M_TVALID}, 32'd0);
      check("midrst_data",  AXIS_M_TDATA, 32'd0);
      check("midrst_err",   {31'd0, ERR}, 32'd0);
      #6;
      RST_N = 1'b1;
      AXIS_M_TREADY = 1'b1;
      tick();
      // Discard a partial packet via reset
      send_beat(32'd9, 1'b0);
      do_reset();
      send_beat(32'd2, 1'b0);
      send_beat(32'd2, 1'b1);
      expect_result("post_rst", 32'd4, 1'b0);

`ifdef AXIS_PKT_ACCUM_STATS_EN
      do_reset();
      for (int p = 0; p < 3; p++) begin
         for (int b = 0; b < 4; b++) send_beat(32'(b + 1), (b == 3));
         expect_result("stat_pkt", 32'd10, 1'b0);
      end
      check("stat_pkts",  STAT_PKTS, 32'd3);
      check("stat_beats", STAT_BEATS, 32'd12);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule

`default_nettype wire
